// File: rtl/cnu_pkg.sv
// Shared constants and elaboration-time helpers for the check-node min accumulator.
package cnu_pkg;

  // Padding lanes carry this value so that they can never win a strict-less compare.
  localparam logic [63:0] ALL_ONES = '1;

  function automatic int cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int clog2c(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int nb_of(input int d, input int p);
    return cdiv(d, p);
  endfunction

  function automatic int bcnt_w_of(input int d, input int p);
    return (nb_of(d, p) <= 1) ? 1 : clog2c(nb_of(d, p));
  endfunction

endpackage

// File: rtl/lane_min2.sv
// Combinational lane stage: min, second min and position of the smallest lane in one beat.
module lane_min2
  import cnu_pkg::*;
#(
  parameter int data_w = 8,
  parameter int idx_w  = 8,
  parameter int P      = 2
) (
  input  logic [data_w*P-1:0] i_mag,
  input  logic [idx_w-1:0]    i_base,
  output logic [data_w-1:0]   o_min,
  output logic [data_w-1:0]   o_min2,
  output logic [idx_w-1:0]    o_idx
);

  logic [data_w-1:0] w_min;
  logic [data_w-1:0] w_min2;
  logic [idx_w-1:0]  w_idx;

  // Lanes are scanned low to high, so a strict compare keeps the lower position on ties.
  always_comb begin
    w_min  = ALL_ONES[data_w-1:0];
    w_min2 = ALL_ONES[data_w-1:0];
    w_idx  = i_base;
    for (int k = 0; k < P; k++) begin
      if (i_mag[k*data_w +: data_w] < w_min) begin
        w_min2 = w_min;
        w_min  = i_mag[k*data_w +: data_w];
        w_idx  = i_base + idx_w'(k);
      end else if (i_mag[k*data_w +: data_w] < w_min2) begin
        w_min2 = i_mag[k*data_w +: data_w];
      end
    end
  end

  assign o_min  = w_min;
  assign o_min2 = w_min2;
  assign o_idx  = w_idx;

endmodule

// File: rtl/cnu_min_acc.sv
// Check-node min/min2 accumulator: folds P lanes per beat over NB beats into one row result.
module cnu_min_acc
  import cnu_pkg::*;
#(
  parameter int data_w = 8,
  parameter int idx_w  = 8,
  parameter int D      = 5,
  parameter int P      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [data_w*P-1:0] in_mag,
  input  logic [P-1:0]        in_sgn,
  input  logic                in_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [data_w-1:0]   min,
  output logic [data_w-1:0]   min2,
  output logic [idx_w-1:0]    min_idx,
  output logic                sgn_prod
);

  localparam int                NB   = nb_of(D, P);
  localparam int                BW   = bcnt_w_of(D, P);
  localparam logic [data_w-1:0] PAD  = ALL_ONES[data_w-1:0];
  localparam logic [BW-1:0]     LAST = BW'(NB - 1);

  logic [BW-1:0]     r_bcnt;
  logic [data_w-1:0] r_acc_min;
  logic [data_w-1:0] r_acc_min2;
  logic [idx_w-1:0]  r_acc_idx;
  logic              r_acc_sgn;
  logic              r_out_valid;
  logic [data_w-1:0] r_min;
  logic [data_w-1:0] r_min2;
  logic [idx_w-1:0]  r_min_idx;
  logic              r_sgn;

  logic [data_w*P-1:0] w_mag;
  logic [P-1:0]        w_sgn;
  logic [idx_w-1:0]    w_base;
  logic [data_w-1:0]   w_l_min;
  logic [data_w-1:0]   w_l_min2;
  logic [idx_w-1:0]    w_l_idx;
  logic [data_w-1:0]   w_m_min;
  logic [data_w-1:0]   w_m_min2;
  logic [idx_w-1:0]    w_m_idx;
  logic                w_m_sgn;
  logic                w_accept;
  logic                w_last;

  // Handshakes: a beat transfers on a rising edge with in_valid && in_ready, a result
  // transfers with out_valid && out_ready; a held result blocks input until it is taken.
  assign in_ready = !(r_out_valid && !out_ready);
  assign w_accept = in_valid && in_ready && !in_clr;
  assign w_last   = (r_bcnt == LAST);
  assign w_base   = idx_w'(r_bcnt) * idx_w'(P);

  // Lanes beyond the row degree only exist on the final beat.
  always_comb begin
    w_mag = in_mag;
    w_sgn = in_sgn;
    for (int k = 0; k < P; k++) begin
      if (int'(r_bcnt) * P + k >= D) begin
        w_mag[k*data_w +: data_w] = PAD;
        w_sgn[k]                  = 1'b0;
      end
    end
  end

  lane_min2 #(
    .data_w (data_w),
    .idx_w  (idx_w),
    .P      (P)
  ) u_lane (
    .i_mag  (w_mag),
    .i_base (w_base),
    .o_min  (w_l_min),
    .o_min2 (w_l_min2),
    .o_idx  (w_l_idx)
  );

  // Accumulated positions are always lower than this beat's, so ties stay with the accumulator.
  always_comb begin
    w_m_sgn = r_acc_sgn ^ (^w_sgn);
    if (w_l_min < r_acc_min) begin
      w_m_min  = w_l_min;
      w_m_idx  = w_l_idx;
      w_m_min2 = (r_acc_min < w_l_min2) ? r_acc_min : w_l_min2;
    end else begin
      w_m_min  = r_acc_min;
      w_m_idx  = r_acc_idx;
      w_m_min2 = (w_l_min < r_acc_min2) ? w_l_min : r_acc_min2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bcnt      <= '0;
      r_acc_min   <= PAD;
      r_acc_min2  <= PAD;
      r_acc_idx   <= '0;
      r_acc_sgn   <= 1'b0;
      r_out_valid <= 1'b0;
      r_min       <= '0;
      r_min2      <= '0;
      r_min_idx   <= '0;
      r_sgn       <= 1'b0;
    end else begin
      if (in_clr || (w_accept && w_last)) begin
        r_bcnt     <= '0;
        r_acc_min  <= PAD;
        r_acc_min2 <= PAD;
        r_acc_idx  <= '0;
        r_acc_sgn  <= 1'b0;
      end else if (w_accept) begin
        r_bcnt     <= r_bcnt + BW'(1);
        r_acc_min  <= w_m_min;
        r_acc_min2 <= w_m_min2;
        r_acc_idx  <= w_m_idx;
        r_acc_sgn  <= w_m_sgn;
      end

      if (w_accept && w_last) begin
        r_min       <= w_m_min;
        r_min2      <= w_m_min2;
        r_min_idx   <= w_m_idx;
        r_sgn       <= w_m_sgn;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign min       = r_min;
  assign min2      = r_min2;
  assign min_idx   = r_min_idx;
  assign sgn_prod  = r_sgn;

endmodule

// File: tb/tb_cnu_min_acc.sv
// Directed and random stimulus for cnu_min_acc with a queue-based row result scoreboard.
module tb_cnu_min_acc;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int D  = 5;
  localparam int P  = 2;
  localparam int NB = 3;
  localparam int EW = DW * 2 + IW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [DW*P-1:0] in_mag;
  logic [P-1:0]  in_sgn;
  logic          in_clr;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] min;
  logic [DW-1:0] min2;
  logic [IW-1:0] min_idx;
  logic          sgn_prod;

  cnu_min_acc #(.data_w(DW), .idx_w(IW), .D(D), .P(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mag    (in_mag),
    .in_sgn    (in_sgn),
    .in_clr    (in_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .min       (min),
    .min2      (min2),
    .min_idx   (min_idx),
    .sgn_prod  (sgn_prod)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_pop = 0;
  int prev_pop = 0;
  bit rmode    = 1'b0;
  bit rforce   = 1'b1;
  logic [EW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output-ready driver: forced level for directed steps, random back-pressure otherwise.
  always @(posedge clk) begin
    #2;
    out_ready = rmode ? ($urandom_range(0, 3) != 0) : rforce;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 32'(exp_q.size()), 32'd1);
      end else begin
        check("sb_row", 32'({min, min2, min_idx, sgn_prod}), 32'(exp_q.pop_front()));
      end
      prev_pop = last_pop;
      last_pop = cyc;
    end
  end

  // Reference: smallest value at its lowest position, then smallest of the remaining positions.
  function automatic logic [EW-1:0] model(input logic [DW*D-1:0] m, input logic [D-1:0] s);
    logic [DW-1:0] mn, mn2;
    logic [IW-1:0] ix;
    mn = m[DW-1:0];
    ix = '0;
    for (int i = 1; i < D; i++) begin
      if (m[i*DW +: DW] < mn) begin
        mn = m[i*DW +: DW];
        ix = IW'(i);
      end
    end
    mn2 = '1;
    for (int i = 0; i < D; i++) begin
      if (IW'(i) != ix && m[i*DW +: DW] < mn2) mn2 = m[i*DW +: DW];
    end
    return {mn, mn2, ix, ^s};
  endfunction

  function automatic logic [DW*D-1:0] pack5(input int a, input int b, input int c,
                                            input int d, input int e);
    return {DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  // Beat b of a row as {signs, magnitudes}; padding lanes get random garbage.
  function automatic logic [P+DW*P-1:0] beat_of(input logic [DW*D-1:0] m,
                                                input logic [D-1:0] s, input int b);
    logic [DW*P-1:0] mg;
    logic [P-1:0]    sg;
    for (int k = 0; k < P; k++) begin
      if (b * P + k < D) begin
        mg[k*DW +: DW] = m[(b*P+k)*DW +: DW];
        sg[k]          = s[b*P+k];
      end else begin
        mg[k*DW +: DW] = DW'($urandom_range(0, 255));
        sg[k]          = 1'($urandom_range(0, 1));
      end
    end
    return {sg, mg};
  endfunction

  // driver tasks: entered and left at posedge+1
  task automatic send_beat(input logic [P+DW*P-1:0] bt, input bit last,
                           input logic [EW-1:0] e, output int waited);
    in_valid = 1'b1;
    in_mag   = bt[DW*P-1:0];
    in_sgn   = bt[P+DW*P-1:DW*P];
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waited++;
      if (waited >= 200) begin
        check("accept_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    if (last && in_ready === 1'b1) exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_row(input logic [DW*D-1:0] m, input logic [D-1:0] s,
                          input bit gaps, output int waits);
    logic [EW-1:0] e;
    int w;
    e     = model(m, s);
    waits = 0;
    for (int b = 0; b < NB; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_beat(beat_of(m, s, b), (b == NB - 1), e, w);
      waits += w;
    end
  endtask

  initial begin
    logic [DW*D-1:0] m;
    logic [D-1:0]    s;
    logic [EW-1:0]   exp_a;
    logic [EW-1:0]   exp_b;
    int w, wsum, t;

    rst      = 1'b0;
    in_valid = 1'b0;
    in_clr   = 1'b0;
    in_mag   = '0;
    in_sgn   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_min", 32'(min), 32'd0);
    check("rst_min2", 32'(min2), 32'd0);
    check("rst_min_idx", 32'(min_idx), 32'd0);
    check("rst_sgn_prod", 32'(sgn_prod), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Tie row with padding lane, one-cycle latency
    send_row(pack5(9, 3, 7, 3, 12), 5'b01101, 1'b0, w);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_min", 32'(min), 32'd3);
    check("basic_min2", 32'(min2), 32'd3);
    check("basic_idx", 32'(min_idx), 32'd1);
    check("basic_sgn", 32'(sgn_prod), 32'd1);

    // Two rows back to back, no bubbles
    send_row(pack5(20, 19, 18, 17, 16), 5'b10000, 1'b0, w);
    wsum = w;
    send_row(pack5(4, 200, 4, 1, 1), 5'b11111, 1'b0, w);
    wsum += w;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_waits", 32'(wsum), 32'd0);
    check("b2b_spacing", 32'(last_pop - prev_pop), 32'd3);

    // Held result blocks the next row until consumed
    rforce = 1'b0;
    m      = pack5(60, 61, 5, 62, 63);
    s      = 5'b00100;
    exp_a  = model(m, s);
    send_row(m, s, 1'b0, w);
    check("hold_valid", 32'(out_valid), 32'd1);
    m      = pack5(33, 34, 35, 30, 31);
    s      = 5'b00011;
    exp_b  = model(m, s);
    in_valid = 1'b1;
    in_mag   = beat_of(m, s, 0) >> 0;
    in_sgn   = '0;
    repeat (4) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_hold_out", 32'({min, min2, min_idx, sgn_prod}), 32'(exp_a));
    end
    @(posedge clk);
    #1;
    rforce = 1'b1;
    send_beat(beat_of(m, s, 0), 1'b0, exp_b, w);
    check("unstall_same_cycle", 32'(w), 32'd0);
    send_beat(beat_of(m, s, 1), 1'b0, exp_b, w);
    send_beat(beat_of(m, s, 2), 1'b1, exp_b, w);
    check("row2_valid", 32'(out_valid), 32'd1);

    // Clear discards the partial row and the beat presented with it
    send_beat(beat_of(pack5(1, 2, 3, 4, 5), 5'b00000, 0), 1'b0, '0, w);
    in_clr   = 1'b1;
    in_valid = 1'b1;
    in_mag   = '0;
    in_sgn   = '1;
    @(posedge clk);
    #1;
    in_clr   = 1'b0;
    in_valid = 1'b0;
    send_row(pack5(50, 40, 30, 20, 10), 5'b00000, 1'b0, w);
    check("clr_min", 32'(min), 32'd10);
    check("clr_min2", 32'(min2), 32'd20);
    check("clr_idx", 32'(min_idx), 32'd4);

    // Reset in the middle of a row
    m = pack5(1, 1, 1, 1, 1);
    send_beat(beat_of(m, 5'b11111, 0), 1'b0, '0, w);
    send_beat(beat_of(m, 5'b11111, 1), 1'b0, '0, w);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_min", 32'(min), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_row(pack5(8, 8, 8, 8, 8), 5'b00000, 1'b0, w);
    check("midrst_min8", 32'(min), 32'd8);
    check("midrst_min2_8", 32'(min2), 32'd8);
    check("midrst_idx", 32'(min_idx), 32'd0);
    check("midrst_sgn", 32'(sgn_prod), 32'd0);

    // All-ones row
    send_row(pack5(255, 255, 255, 255, 255), 5'b00001, 1'b0, w);
    check("ones_idx", 32'(min_idx), 32'd0);
    check("ones_min2", 32'(min2), 32'd255);

    // Random rows with valid gaps and ready stalls
    rmode = 1'b1;
    for (int it = 0; it < 10000; it++) begin
      for (int i = 0; i < D; i++) begin
        case ($urandom_range(0, 9))
          0:       m[i*DW +: DW] = 8'hFF;
          1, 2, 3: m[i*DW +: DW] = DW'($urandom_range(0, 3));
          default: m[i*DW +: DW] = DW'($urandom_range(0, 255));
        endcase
      end
      if (it % 97 == 0) m = '1;
      s = D'($urandom_range(0, 31));
      send_row(m, s, 1'b1, w);
    end
    rmode = 1'b0;

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
